// File: rtl/frame_diff_pkg.sv
// Shared types and constants for the frame-difference front end:
// FSM state encoding, default geometry, address-width derivation and
// the power-on difference threshold.
package frame_diff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FILL,
        RUN
    } state_t;

    localparam int DEF_HDISP     = 640;
    localparam int DEF_VDISP     = 480;
    localparam int DEF_FRAME_PIX = DEF_HDISP * DEF_VDISP;

    localparam logic [7:0] DEF_THRESHOLD = 8'd60;

    // Pixels in one frame.
    function automatic int frame_pix(input int hdisp, input int vdisp);
        return hdisp * vdisp;
    endfunction

    // Smallest per-bank address width able to hold npix pixels.
    function automatic int pix_addr_w(input int npix);
        return (npix <= 2) ? 1 : $clog2(npix);
    endfunction

    localparam int PIX_ADDR_W = pix_addr_w(DEF_FRAME_PIX);

endpackage

// File: rtl/sig_delay_line.sv
// Fixed-depth shift register used to realign timing/pixel signals with
// the memory read return. The whole line clears on reset so delayed
// outputs read as zero until real data has propagated through.
module sig_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_p [DEPTH];

    // Shift din one stage per clock; clear every stage on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_p[i] <= '0;
            end
        end else begin
            pipe_p[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_p[i] <= pipe_p[i-1];
            end
        end
    end

    assign dout = pipe_p[DEPTH-1];

endmodule

// File: rtl/frame_store_sched.sv
// Two-bank frame store sequencer. Each captured frame is written to
// wr_bank while the previous good frame is read from the other bank at
// the same pixel address; the read data is realigned with the current
// pixel so the difference stage sees both lumas in the same cycle.
module frame_store_sched
    import frame_diff_pkg::*;
#(
    parameter int IMG_HDISP = DEF_HDISP,
    parameter int IMG_VDISP = DEF_VDISP,
    parameter int ADDR_W    = PIX_ADDR_W,
    parameter int RD_LAT    = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              ctrl_en,
    input  logic              clear_prev,
    input  logic [7:0]        threshold_in,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [7:0]        per_img_Y,
    output logic              mem_wr_en,
    output logic [ADDR_W:0]   mem_wr_addr,
    output logic [7:0]        mem_wr_data,
    output logic              mem_rd_en,
    output logic [ADDR_W:0]   mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [7:0]        post_img_Y,
    output logic [7:0]        post_img_Y_pre,
    output logic              diff_en,
    output logic [7:0]        diff_threshold,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);

    localparam int FRAME_PIX = frame_pix(IMG_HDISP, IMG_VDISP);
    // One extra bit so the counter can hold FRAME_PIX itself even when
    // FRAME_PIX == 2**ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FRAME_PIX_C = CNT_W'(FRAME_PIX);
    localparam int ALIGN_D = 1 + RD_LAT;
    localparam int BUS_W   = 12;

    state_t           state_q, state_d;
    logic             vsync_p0;
    logic             sof, eof;
    logic             start_frame, eof_good, eof_bad;
    logic             wr_bank, prev_valid, ovf;
    logic [CNT_W-1:0] pix_cnt;
    logic             capturing, pix_hit, cnt_full, accept;
    logic             rd_vld_p0, rd_vld_pd;
    logic [BUS_W-1:0] bus_p0, bus_pd;

    // SOF needs vsync high and EOF needs vsync low in the same cycle,
    // so the two edge strobes can never fire together.
    assign sof = per_frame_vsync & ~vsync_p0;
    assign eof = ~per_frame_vsync & vsync_p0;

    assign capturing = (state_q == FILL) || (state_q == RUN);
    assign pix_hit   = per_frame_href & per_frame_clken & capturing;
    assign cnt_full  = (pix_cnt == FRAME_PIX_C);
    // Accepts beyond a full frame are dropped so addresses never wrap.
    assign accept    = pix_hit & ~cnt_full;
    // A clear in this very cycle already suppresses this pixel's read.
    assign rd_vld_p0 = accept & (state_q == RUN) & prev_valid & ~clear_prev;

    // Next-state and frame-boundary decisions.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        eof_good    = 1'b0;
        eof_bad     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!per_frame_vsync) state_d = ARM;
            end
            ARM: begin
                if (sof && ctrl_en) begin
                    start_frame = 1'b1;
                    state_d     = prev_valid ? RUN : FILL;
                end
            end
            FILL, RUN: begin
                if (eof) begin
                    state_d = ARM;
                    if (cnt_full && !ovf) eof_good = 1'b1;
                    else                  eof_bad  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, edge history, pixel counter, bank and validity.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q        <= IDLE;
            vsync_p0       <= 1'b0;
            wr_bank        <= 1'b0;
            prev_valid     <= 1'b0;
            pix_cnt        <= '0;
            ovf            <= 1'b0;
            diff_threshold <= DEF_THRESHOLD;
            frame_cnt      <= '0;
            frame_err      <= 1'b0;
        end else begin
            state_q   <= state_d;
            vsync_p0  <= per_frame_vsync;
            frame_err <= eof_bad;
            if (start_frame) begin
                pix_cnt        <= '0;
                ovf            <= 1'b0;
                diff_threshold <= threshold_in;
            end else begin
                if (accept)              pix_cnt <= pix_cnt + CNT_W'(1);
                if (pix_hit && cnt_full) ovf     <= 1'b1;
            end
            if (eof_good) begin
                wr_bank   <= ~wr_bank;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (clear_prev)    prev_valid <= 1'b0;
            else if (eof_good) prev_valid <= 1'b1;
        end
    end

    // Memory requests, one cycle after the accept; read and write share
    // the pixel address but always target opposite banks.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            mem_wr_en   <= accept;
            mem_wr_addr <= {wr_bank, pix_cnt[ADDR_W-1:0]};
            mem_wr_data <= per_img_Y;
            mem_rd_en   <= rd_vld_p0;
            mem_rd_addr <= {~wr_bank, pix_cnt[ADDR_W-1:0]};
        end
    end

    assign bus_p0 = {per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y, rd_vld_p0};

    sig_delay_line #(
        .WIDTH (BUS_W),
        .DEPTH (ALIGN_D)
    ) u_align (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (bus_p0),
        .dout (bus_pd)
    );

    assign {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y, rd_vld_pd} = bus_pd;
    assign diff_en        = rd_vld_pd;
    assign post_img_Y_pre = rd_vld_pd ? mem_rd_data : 8'd0;

endmodule

// File: tb/tb_frame_store_sched.sv
// Randomized bench for frame_store_sched on an 8x4 image with a
// behavioural two-bank RAM. A frame-level model predicts writes, reads,
// frame outcomes and the realigned pixel stream.
module tb_frame_store_sched;
    import frame_diff_pkg::*;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int NPIX = H * V;
    localparam int AW   = pix_addr_w(NPIX);
    localparam int RL   = 2;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          ctrl_en = 1'b0;
    logic          clear_prev = 1'b0;
    logic [7:0]    threshold_in = 8'd60;
    logic          per_frame_vsync = 1'b0;
    logic          per_frame_href = 1'b0;
    logic          per_frame_clken = 1'b0;
    logic [7:0]    per_img_Y = 8'd0;
    logic          mem_wr_en, mem_rd_en;
    logic [AW:0]   mem_wr_addr, mem_rd_addr;
    logic [7:0]    mem_wr_data, mem_rd_data;
    logic          post_frame_vsync, post_frame_href, post_frame_clken;
    logic [7:0]    post_img_Y, post_img_Y_pre, diff_threshold;
    logic          diff_en, frame_err;
    logic [15:0]   frame_cnt;

    frame_store_sched #(
        .IMG_HDISP (H),
        .IMG_VDISP (V),
        .ADDR_W    (AW),
        .RD_LAT    (RL)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .ctrl_en          (ctrl_en),
        .clear_prev       (clear_prev),
        .threshold_in     (threshold_in),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .mem_wr_en        (mem_wr_en),
        .mem_wr_addr      (mem_wr_addr),
        .mem_wr_data      (mem_wr_data),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_data      (mem_rd_data),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y),
        .post_img_Y_pre   (post_img_Y_pre),
        .diff_en          (diff_en),
        .diff_threshold   (diff_threshold),
        .frame_err        (frame_err),
        .frame_cnt        (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural RAM: two banks, read data returned RL cycles after mem_rd_en.
    logic [7:0] ram [2][NPIX];
    logic [7:0] rd_s1, rd_s2;
    always @(posedge sys_clk) begin
        if (mem_wr_en) ram[mem_wr_addr[AW]][mem_wr_addr[AW-1:0]] <= mem_wr_data;
        rd_s1 <= mem_rd_en ? ram[mem_rd_addr[AW]][mem_rd_addr[AW-1:0]] : 8'hA5;
        rd_s2 <= rd_s1;
    end
    assign mem_rd_data = rd_s2;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expectation attached to the pixel currently driven.
    logic          cur_rd = 1'b0;
    logic [7:0]    cur_pre = 8'd0;

    // Monitor: input history for alignment, plus request and error logs.
    logic [19:0]   hist [$];
    logic [19:0]   mon_e;
    logic [AW+8:0] wr_q [$];
    logic [AW:0]   rd_q [$];
    int            err_seen = 0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            hist.delete();
            for (int i = 0; i < 1 + RL; i++) hist.push_back('0);
        end else begin
            hist.push_back({per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y, cur_pre, cur_rd});
            mon_e = hist.pop_front();
            chk("post_align",
                {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y, post_img_Y_pre, diff_en},
                mon_e);
            if (frame_err) err_seen++;
            if (mem_wr_en) wr_q.push_back({mem_wr_addr, mem_wr_data});
            if (mem_rd_en) rd_q.push_back(mem_rd_addr);
        end
    end

    // Frame-level reference model.
    logic          m_pv = 1'b0;
    logic          m_bank = 1'b0;
    int            m_cnt = 0;
    logic [7:0]    m_thr = DEF_THRESHOLD;
    logic [7:0]    m_store [2][NPIX];

    task automatic cyc(input logic vs, input logic hs, input logic ck,
                       input logic [7:0] y, input logic rd, input logic [7:0] pre);
        per_frame_vsync = vs;
        per_frame_href  = hs;
        per_frame_clken = ck;
        per_img_Y       = y;
        cur_rd          = rd;
        cur_pre         = pre;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, {mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
                  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y,
                  post_img_Y_pre, diff_en, frame_err, frame_cnt}, 64'd0);
        chk({tag, "_thr"}, diff_threshold, DEF_THRESHOLD);
    endtask

    task automatic run_frame(input int npix, input logic cen, input int clr_at,
                             input int thr_at, input logic [7:0] thr_new, input int rst_at);
        logic [7:0]    base, y, pre;
        logic          cap, run_mode, cleared, rd, exp_err;
        logic [7:0]    fv [NPIX];
        logic [AW+8:0] exp_wr [$];
        logic [AW:0]   exp_rd [$];
        base    = 8'($urandom);
        ctrl_en = cen;
        cleared = 1'b0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'd0, 0, 8'd0);
        wr_q.delete();
        rd_q.delete();
        err_seen = 0;
        // Start of frame: capture decision and threshold shadowing.
        cap      = cen;
        run_mode = m_pv;
        if (cap) m_thr = threshold_in;
        cyc(1, 0, 0, 8'd0, 0, 8'd0);
        cyc(1, 0, 0, 8'd0, 0, 8'd0);
        for (int p = 0; p < npix; p++) begin
            if (p > 0 && p % H == 0) begin
                cyc(1, 0, 0, 8'($urandom), 0, 8'd0);
                cyc(1, 0, 0, 8'($urandom), 0, 8'd0);
            end
            if ($urandom_range(0, 3) == 0) cyc(1, 1, 0, 8'($urandom), 0, 8'd0);
            if (p == rst_at) begin
                sys_rst = 1'b1;
                cyc(1, 0, 0, 8'd0, 0, 8'd0);
                cyc(1, 0, 0, 8'd0, 0, 8'd0);
                check_reset_outputs("rst_mid");
                sys_rst = 1'b0;
                m_pv   = 1'b0;
                m_bank = 1'b0;
                m_cnt  = 0;
                m_thr  = DEF_THRESHOLD;
                for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'd0, 0, 8'd0);
                return;
            end
            if (p == clr_at) begin
                clear_prev = 1'b1;
                cleared    = 1'b1;
            end
            if (p == thr_at) threshold_in = thr_new;
            y   = base + 8'(p);
            rd  = cap && run_mode && !cleared && (p < NPIX);
            pre = 8'd0;
            if (rd) begin
                pre = m_store[~m_bank][p];
                exp_rd.push_back({~m_bank, AW'(p)});
            end
            if (cap && p < NPIX) begin
                exp_wr.push_back({m_bank, AW'(p), y});
                fv[p] = y;
            end
            cyc(1, 1, 1, y, rd, pre);
            clear_prev = 1'b0;
            if (p == thr_at) chk("thr_hold", diff_threshold, m_thr);
        end
        cyc(1, 0, 0, 8'd0, 0, 8'd0);
        cyc(1, 0, 0, 8'd0, 0, 8'd0);
        // End of frame outcome.
        exp_err = 1'b0;
        if (cap) begin
            if (npix == NPIX) begin
                for (int i = 0; i < NPIX; i++) m_store[m_bank][i] = fv[i];
                m_bank = ~m_bank;
                m_pv   = 1'b1;
                m_cnt++;
            end else begin
                exp_err = 1'b1;
                if (cleared) m_pv = 1'b0;
            end
        end else if (cleared) begin
            m_pv = 1'b0;
        end
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'd0, 0, 8'd0);
        chk("frame_err", err_seen, exp_err);
        chk("frame_cnt", frame_cnt, 16'(m_cnt));
        chk("threshold", diff_threshold, m_thr);
        chk("wr_count", wr_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) chk("wr_req", wr_q[i], exp_wr[i]);
        chk("rd_count", rd_q.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++) chk("rd_req", rd_q[i], exp_rd[i]);
    endtask

    initial begin
        int n;
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'd0, 0, 8'd0);
        check_reset_outputs("rst_init");
        sys_rst = 1'b0;

        // Three good frames: FILL then two RUN frames.
        threshold_in = 8'd60;
        for (int f = 0; f < 3; f++) run_frame(NPIX, 1, -1, -1, 8'd0, -1);

        // Short frame, then a good one still reading the old previous bank.
        run_frame(30, 1, -1, -1, 8'd0, -1);
        run_frame(NPIX, 1, -1, -1, 8'd0, -1);

        // Long frame saturates at a full frame and flags an error.
        run_frame(35, 1, -1, -1, 8'd0, -1);

        // Threshold change mid-frame takes effect only at the next start.
        threshold_in = 8'd60;
        run_frame(NPIX, 1, -1, 5, 8'd90, -1);
        run_frame(NPIX, 1, -1, -1, 8'd0, -1);

        // Capture disabled for one frame, then resumed.
        run_frame(NPIX, 0, -1, -1, 8'd0, -1);
        run_frame(NPIX, 1, -1, -1, 8'd0, -1);

        // Random mix of lengths, enables and thresholds.
        for (int k = 0; k < 8; k++) begin
            threshold_in = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       n = NPIX - 1;
                1:       n = NPIX + 1;
                default: n = NPIX;
            endcase
            run_frame(n, ($urandom_range(0, 3) != 0), -1, -1, 8'd0, -1);
        end

        // clear_prev in a RUN frame that completes, then clear plus reset mid-frame.
        run_frame(NPIX, 1, -1, -1, 8'd0, -1);
        run_frame(NPIX, 1, 10, -1, 8'd0, -1);
        run_frame(NPIX, 1, 8, -1, 8'd0, 20);
        run_frame(NPIX, 1, -1, -1, 8'd0, -1);
        run_frame(NPIX, 1, -1, -1, 8'd0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
